// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key schedule: expands one 32-bit word per clock into a round-key
// buffer and serves whole round keys through a registered, pipelined read port.
module aes_key_schedule #(
    parameter int unsigned regSize = 32,
    parameter int unsigned vecSize = 4,
    parameter int unsigned NK_MAX  = 8,
    parameter int unsigned NR_MAX  = 14
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [1:0]                       mode,
    input  logic [NK_MAX-1:0][regSize-1:0]   key_in,
    output logic                             busy,
    output logic                             done,
    output logic                             keys_valid,
    output logic [3:0]                       cur_nr,
    output logic                             err,
    input  logic                             rd_en,
    input  logic [3:0]                       rd_round,
    output logic [vecSize-1:0][regSize-1:0]  rd_data,
    output logic                             rd_valid,
    output logic                             rd_err
);
    localparam int unsigned DEPTH = vecSize * (NR_MAX + 1);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(NK_MAX);
    localparam int unsigned BYTES = regSize / 8;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [regSize-1:0] sub_word(input logic [regSize-1:0] w);
        logic [regSize-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            r[8*b +: 8] = SBOX[w[8*b +: 8]];
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t                       state;
    logic [AW-1:0]                i_q;
    logic [AW-1:0]                last_q;
    logic [CW-1:0]                imod_q;
    logic [3:0]                   nk_q;
    logic [3:0]                   nr_q;
    logic [7:0]                   rcon_q;
    logic [DEPTH-1:0][regSize-1:0] buf_q;

    logic [3:0]                   nk_new_c;
    logic [3:0]                   nr_new_c;
    logic [AW-1:0]                last_new_c;
    logic [AW-1:0]                rd_base_c;
    logic [regSize-1:0]           w_prev_c;
    logic [regSize-1:0]           w_back_c;
    logic [regSize-1:0]           temp_c;
    logic [regSize-1:0]           w_new_c;
    logic                         accept_c;
    logic                         expand_c;
    logic                         imod_wrap_c;

    // Key-size decode; the illegal mode never reaches the latches because accept_c excludes it.
    always_comb begin
        nk_new_c = 4'd4;
        nr_new_c = 4'd10;
        case (mode)
            2'd1: begin
                nk_new_c = 4'd6;
                nr_new_c = 4'd12;
            end
            2'd2: begin
                nk_new_c = 4'd8;
                nr_new_c = 4'd14;
            end
            default: begin
                nk_new_c = 4'd4;
                nr_new_c = 4'd10;
            end
        endcase
    end

    assign last_new_c  = AW'(vecSize * (32'(nr_new_c) + 32'd1) - 32'd1);
    assign rd_base_c   = AW'(vecSize * 32'(rd_round));
    assign accept_c    = rst_n && start && (mode != 2'd3) && (state != EXPAND);
    assign expand_c    = rst_n && (state == EXPAND);
    assign imod_wrap_c = (imod_q == CW'(nk_q - 4'd1));

    // Next schedule word from w[i-1] and w[i-Nk].
    always_comb begin
        w_prev_c = buf_q[i_q - AW'(1)];
        w_back_c = buf_q[i_q - AW'(nk_q)];
        temp_c   = w_prev_c;
        if (imod_q == '0) begin
            temp_c = sub_word({w_prev_c[regSize-9:0], w_prev_c[regSize-1:regSize-8]})
                     ^ {rcon_q, {(regSize-8){1'b0}}};
        end else if ((nk_q == 4'd8) && (imod_q == CW'(4))) begin
            temp_c = sub_word(w_prev_c);
        end
        w_new_c = w_back_c ^ temp_c;
    end

    // Round-key buffer: key load on an accepted start, one schedule word per EXPAND cycle.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            for (int unsigned j = 0; j < NK_MAX; j++) begin
                if (j < 32'(nk_new_c)) begin
                    buf_q[AW'(j)] <= key_in[CW'(j)];
                end
            end
        end
        if (expand_c) begin
            buf_q[i_q] <= w_new_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            cur_nr     <= 4'd0;
            err        <= 1'b0;
            rd_valid   <= 1'b0;
            rd_err     <= 1'b0;
            rd_data    <= '0;
            i_q        <= '0;
            last_q     <= '0;
            imod_q     <= '0;
            nk_q       <= 4'd4;
            nr_q       <= 4'd10;
            rcon_q     <= 8'h01;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start && (mode == 2'd3)) begin
                        err <= 1'b1;
                    end else if (accept_c) begin
                        nk_q       <= nk_new_c;
                        nr_q       <= nr_new_c;
                        last_q     <= last_new_c;
                        i_q        <= AW'(nk_new_c);
                        imod_q     <= '0;
                        rcon_q     <= 8'h01;
                        keys_valid <= 1'b0;
                        busy       <= 1'b1;
                        state      <= EXPAND;
                    end
                end
                EXPAND: begin
                    i_q    <= i_q + AW'(1);
                    imod_q <= imod_wrap_c ? '0 : imod_q + CW'(1);
                    if (imod_q == '0) begin
                        rcon_q <= xtime(rcon_q);
                    end
                    if (i_q == last_q) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                        cur_nr     <= nr_q;
                    end
                end
                default: state <= IDLE;
            endcase

            // Reads see the pre-edge schedule, so a read alongside a restart returns old keys.
            if (rd_en) begin
                if (keys_valid && (rd_round <= cur_nr)) begin
                    rd_valid <= 1'b1;
                    rd_err   <= 1'b0;
                    for (int unsigned j = 0; j < vecSize; j++) begin
                        rd_data[j] <= buf_q[rd_base_c + AW'(j)];
                    end
                end else begin
                    rd_valid <= 1'b0;
                    rd_err   <= 1'b1;
                    rd_data  <= '0;
                end
            end else begin
                rd_valid <= 1'b0;
                rd_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: FIPS-197 style reference model, per-cycle
// output comparison, directed known-answer runs and a randomized phase.
module tb_aes_key_schedule;
    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [1:0]            mode;
    logic [7:0][31:0]      key_in;
    logic                  busy, done, keys_valid, err;
    logic [3:0]            cur_nr;
    logic                  rd_en;
    logic [3:0]            rd_round;
    logic [3:0][31:0]      rd_data;
    logic                  rd_valid, rd_err;

    aes_key_schedule dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key_in(key_in),
        .busy(busy), .done(done), .keys_valid(keys_valid), .cur_nr(cur_nr), .err(err),
        .rd_en(rd_en), .rd_round(rd_round), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  sbox_t [256];
    logic [31:0] xw     [60];
    logic [31:0] pend_w [60];
    logic [31:0] m_sched[60];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_of(input int j);
        logic [7:0] r;
        r = 8'h01;
        for (int t = 1; t < j; t++) r = gmul(r, 8'h02);
        return r;
    endfunction

    function automatic void model_expand(input logic [7:0][31:0] k, input int nk, input int nr);
        logic [31:0] t;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) xw[i] = k[i];
            else begin
                t = xw[i-1];
                if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
                else if (nk > 6 && i % nk == 4) t = subw(t);
                xw[i] = xw[i-nk] ^ t;
            end
        end
    endfunction

    function automatic logic [7:0][31:0] rand_key();
        logic [7:0][31:0] k;
        for (int j = 0; j < 8; j++) k[j] = $urandom;
        return k;
    endfunction

    // Transaction-level expected outputs: remaining cycles of the running expansion plus
    // the last completed schedule.
    bit              m_init = 1'b0;
    int              m_rem = 0;
    logic            m_busy, m_done, m_kv, m_err, m_rv, m_re;
    logic [3:0]      m_nr, pend_nr;
    logic [3:0][31:0] m_rd;

    always @(posedge clk) begin
        int nk, nr;
        if (!rst_n) begin
            m_init = 1'b1; m_rem = 0; m_done = 1'b0; m_kv = 1'b0; m_nr = 4'd0;
            m_err = 1'b0; m_rv = 1'b0; m_re = 1'b0; m_rd = '0;
        end else begin
            if (rd_en) begin
                if (m_kv && rd_round <= m_nr) begin
                    m_rv = 1'b1; m_re = 1'b0;
                    for (int j = 0; j < 4; j++) m_rd[j] = m_sched[4 * int'(rd_round) + j];
                end else begin
                    m_rv = 1'b0; m_re = 1'b1; m_rd = '0;
                end
            end else begin
                m_rv = 1'b0; m_re = 1'b0;
            end
            m_done = 1'b0; m_err = 1'b0;
            if (m_rem != 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1; m_kv = 1'b1; m_nr = pend_nr;
                    for (int j = 0; j < 60; j++) m_sched[j] = pend_w[j];
                end
            end else if (start) begin
                if (mode == 2'd3) m_err = 1'b1;
                else begin
                    nk = (mode == 2'd0) ? 4 : (mode == 2'd1) ? 6 : 8;
                    nr = nk + 6;
                    model_expand(key_in, nk, nr);
                    for (int j = 0; j < 60; j++) pend_w[j] = xw[j];
                    pend_nr = 4'(nr);
                    m_rem = 4 * (nr + 1) - nk;
                    m_kv = 1'b0;
                end
            end
        end
        m_busy = (m_rem != 0);
        #1;
        if (m_init) begin
            chk("busy", 128'(busy), 128'(m_busy));
            chk("done", 128'(done), 128'(m_done));
            chk("keys_valid", 128'(keys_valid), 128'(m_kv));
            chk("cur_nr", 128'(cur_nr), 128'(m_nr));
            chk("err", 128'(err), 128'(m_err));
            chk("rd_valid", 128'(rd_valid), 128'(m_rv));
            chk("rd_err", 128'(rd_err), 128'(m_re));
            chk("rd_data", rd_data, m_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_start(input logic [1:0] m, input logic [7:0][31:0] k, input bit inject,
                             input int rst_at, output int lat);
        lat = -1;
        @(negedge clk); start = 1'b1; mode = m; key_in = k;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start    = inject && (n == 6);
            if (inject && n == 6) begin mode = 2'd2; key_in = rand_key(); end
            rd_en    = inject && (n == 3 || n == 4);
            rd_round = 4'd0;
            rst_n    = !(rst_at == n);
            @(posedge clk); #1;
            if (rst_at == n) begin lat = n; break; end
            if (done) begin lat = n; break; end
        end
        @(negedge clk); start = 1'b0; rd_en = 1'b0; rst_n = 1'b1;
    endtask

    task automatic do_read(input logic [3:0] r, output logic [127:0] d, output logic v, output logic e);
        @(negedge clk); rd_en = 1'b1; rd_round = r;
        @(posedge clk); #1;
        d = rd_data; v = rd_valid; e = rd_err;
        @(negedge clk); rd_en = 1'b0;
    endtask

    logic [7:0][31:0] k128, k192, k256;
    logic [127:0]     d;
    logic             v, e;
    int               lat;

    localparam logic [127:0] FIPS128_R10 = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};
    localparam logic [127:0] FIPS192_R12 = {32'h01002202, 32'h8ecc7204, 32'h448c773c, 32'he98ba06f};
    localparam logic [127:0] FIPS256_R14 = {32'h706c631e, 32'h046df344, 32'he6188d0b, 32'hfe4890d1};
    localparam logic [127:0] ZERO_R10    = {32'h6f8f188e, 32'h23e951cf, 32'h3e92e211, 32'hb4ef5bcb};

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 2'd0; key_in = '0; rd_en = 1'b0; rd_round = 4'd0;
        k128 = '0; k192 = '0; k256 = '0;
        k128[0] = 32'h2b7e1516; k128[1] = 32'h28aed2a6; k128[2] = 32'habf71588; k128[3] = 32'h09cf4f3c;
        k192[0] = 32'h8e73b0f7; k192[1] = 32'hda0e6452; k192[2] = 32'hc810f32b;
        k192[3] = 32'h809079e5; k192[4] = 32'h62f8ead2; k192[5] = 32'h522c6b7b;
        k256[0] = 32'h603deb10; k256[1] = 32'h15ca71be; k256[2] = 32'h2b73aef0; k256[3] = 32'h857d7781;
        k256[4] = 32'h1f352c07; k256[5] = 32'h3b6108d7; k256[6] = 32'h2d9810a3; k256[7] = 32'h0914dff4;

        // Pin the model against known values before it is used as a reference.
        build_sbox();
        chk("model_sbox_00", 128'(sbox_t[0]), 128'h63);
        chk("model_sbox_53", 128'(sbox_t[8'h53]), 128'hed);
        model_expand('0, 4, 10);
        chk("model_zero_w4", 128'(xw[4]), 128'h62636363);
        chk("model_zero_w43", 128'(xw[43]), 128'h6f8f188e);
        model_expand(k256, 8, 14);
        chk("model_256_w59", 128'(xw[59]), 128'h706c631e);

        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        chk("reset_busy", 128'(busy), 128'h0);
        chk("reset_kv", 128'(keys_valid), 128'h0);
        chk("reset_rd_data", rd_data, 128'h0);

        run_start(2'd0, '0, 1'b0, 0, lat);
        chk("lat_aes128_zero", 128'(lat), 128'd40);
        do_read(4'd1, d, v, e);
        chk("zero_r1", d, {4{32'h62636363}});
        chk("zero_r1_valid", 128'(v), 128'h1);
        do_read(4'd10, d, v, e);
        chk("zero_r10", d, ZERO_R10);
        do_read(4'd11, d, v, e);
        chk("r11_err", 128'(e), 128'h1);
        chk("r11_data", d, 128'h0);
        chk("cur_nr_128", 128'(cur_nr), 128'd10);

        // Reads and a second start during EXPAND must not disturb the run.
        run_start(2'd0, k128, 1'b1, 0, lat);
        chk("lat_aes128_inject", 128'(lat), 128'd40);
        do_read(4'd10, d, v, e);
        chk("fips128_r10", d, FIPS128_R10);

        // Restart from DONE with a read in the same cycle: old data, start accepted.
        @(negedge clk); start = 1'b1; mode = 2'd1; key_in = k192; rd_en = 1'b1; rd_round = 4'd10;
        @(posedge clk); #1;
        chk("restart_rd_valid", 128'(rd_valid), 128'h1);
        chk("restart_rd_data", rd_data, FIPS128_R10);
        chk("restart_busy", 128'(busy), 128'h1);
        chk("restart_kv", 128'(keys_valid), 128'h0);
        @(negedge clk); start = 1'b0; rd_en = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin @(posedge clk); #1; if (!done) lat++; end
        chk("lat_aes192", 128'(lat), 128'd46);
        do_read(4'd12, d, v, e);
        chk("fips192_r12", d, FIPS192_R12);
        chk("cur_nr_192", 128'(cur_nr), 128'd12);

        run_start(2'd2, k256, 1'b0, 0, lat);
        chk("lat_aes256", 128'(lat), 128'd52);
        do_read(4'd14, d, v, e);
        chk("fips256_r14", d, FIPS256_R14);
        chk("cur_nr_256", 128'(cur_nr), 128'd14);

        @(negedge clk); start = 1'b1; mode = 2'd3;
        @(posedge clk); #1;
        chk("mode3_err", 128'(err), 128'h1);
        chk("mode3_busy", 128'(busy), 128'h0);
        chk("mode3_kv", 128'(keys_valid), 128'h1);
        @(negedge clk); start = 1'b0; mode = 2'd0;
        @(posedge clk); #1;
        chk("mode3_err_drop", 128'(err), 128'h0);
        do_read(4'd14, d, v, e);
        chk("mode3_keys_kept", d, FIPS256_R14);

        run_start(2'd0, rand_key(), 1'b0, 20, lat);
        chk("midrst_busy", 128'(busy), 128'h0);
        chk("midrst_kv", 128'(keys_valid), 128'h0);
        chk("midrst_cur_nr", 128'(cur_nr), 128'h0);
        run_start(2'd0, k128, 1'b0, 0, lat);
        chk("lat_after_rst", 128'(lat), 128'd40);
        do_read(4'd10, d, v, e);
        chk("after_rst_r10", d, FIPS128_R10);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 29) == 0);
            mode     = 2'($urandom_range(0, 3));
            if (start) key_in = rand_key();
            rd_en    = 1'($urandom_range(0, 1));
            rd_round = 4'($urandom_range(0, 15));
            rst_n    = ($urandom_range(0, 599) != 0);
        end
        @(negedge clk); start = 1'b0; rd_en = 1'b0; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
